// File: rtl/array_wr_ctrl.sv
// array_wr_ctrl: write-path back end of the memory controller.
// Takes the write frame stream from fsm_ctrl and performs one burst on the
// array: open the row, write one column per frame, wait write recovery,
// precharge, then pulse wr_done so fsm_ctrl can return to arbitration.
module array_wr_ctrl #(
  parameter int AXI_ADDR_WIDTH  = 20,
  parameter int AXI_DATA_WIDTH  = 64,
  parameter int AXI_FRAME_WIDTH = AXI_ADDR_WIDTH + AXI_DATA_WIDTH + 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 mc_trcd_cfg,
  input  logic [7:0]                 mc_twr_cfg,
  input  logic [7:0]                 mc_trp_cfg,
  input  logic [AXI_FRAME_WIDTH-1:0] axi_frame_wr_data,
  input  logic                       axi_frame_wr_valid,
  output logic                       axi_frame_wr_ready,
  output logic                       wr_done,
  output logic                       array_banksel_n,
  output logic [13:0]                array_raddr,
  output logic                       array_cas_wr,
  output logic [5:0]                 array_caddr_wr,
  output logic [AXI_DATA_WIDTH-1:0]  array_wdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROW_OPEN,
    S_WR_CMD,
    S_WR_WAIT,
    S_WR_RECOVER,
    S_PRECHARGE,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_next;
  logic       r_eof;

  // Frame fields: {sof, eof, wr, addr, data} with sof at the MSB.
  logic                      w_sof;
  logic                      w_eof;
  logic [AXI_ADDR_WIDTH-1:0] w_addr;
  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic                      w_unused_wr;
  logic                      w_accept;
  logic                      w_load_frame;

  assign w_sof       = axi_frame_wr_data[AXI_FRAME_WIDTH-1];
  assign w_eof       = axi_frame_wr_data[AXI_FRAME_WIDTH-2];
  // The wr flag is never interpreted; only write frames are routed here.
  assign w_unused_wr = axi_frame_wr_data[AXI_FRAME_WIDTH-3];
  assign w_addr      = axi_frame_wr_data[AXI_ADDR_WIDTH+AXI_DATA_WIDTH-1:AXI_DATA_WIDTH];
  assign w_data      = axi_frame_wr_data[AXI_DATA_WIDTH-1:0];

  // Ready is decoded straight from the state register, gated by reset.
  assign axi_frame_wr_ready = ~rst & ((r_state == S_IDLE) || (r_state == S_WR_WAIT));
  assign w_accept           = axi_frame_wr_valid & axi_frame_wr_ready;

  // A frame carries column/data worth keeping when it opens a burst (sof in
  // IDLE) or continues one; sof=0 frames seen in IDLE are dropped.
  assign w_load_frame = w_accept & ((r_state == S_WR_WAIT) || ((r_state == S_IDLE) && w_sof));

  // Timed states count max(cfg,1) cycles: load max(cfg,1)-1, leave at 0.
  function automatic logic [7:0] delay_load(input logic [7:0] cfg);
    return (cfg == 8'd0) ? 8'd0 : cfg - 8'd1;
  endfunction

  // Next-state and delay-counter decode.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned, which would infer a latch.
    w_next     = r_state;
    w_cnt_next = r_cnt;
    unique case (r_state)
      S_IDLE:       if (w_accept && w_sof) w_next = S_ROW_OPEN;
      S_ROW_OPEN:   if (r_cnt == 8'd0) w_next = S_WR_CMD;
      S_WR_CMD:     w_next = r_eof ? S_WR_RECOVER : S_WR_WAIT;
      S_WR_WAIT:    if (w_accept) w_next = S_WR_CMD;
      S_WR_RECOVER: if (r_cnt == 8'd0) w_next = S_PRECHARGE;
      S_PRECHARGE:  if (r_cnt == 8'd0) w_next = S_DONE;
      S_DONE:       w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
    // The cfg value is sampled only on entry, so mid-state changes are ignored.
    if (w_next != r_state) begin
      unique case (w_next)
        S_ROW_OPEN:   w_cnt_next = delay_load(mc_trcd_cfg);
        S_WR_RECOVER: w_cnt_next = delay_load(mc_twr_cfg);
        S_PRECHARGE:  w_cnt_next = delay_load(mc_trp_cfg);
        default:      w_cnt_next = r_cnt;
      endcase
    end else if (r_cnt != 8'd0) begin
      w_cnt_next = r_cnt - 8'd1;
    end
  end

  // State register and delay counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Registered array outputs, decoded from the next state so they line up
  // with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      array_banksel_n <= 1'b1;
      array_cas_wr    <= 1'b0;
      wr_done         <= 1'b0;
      array_raddr     <= 14'd0;
      array_caddr_wr  <= 6'd0;
      array_wdata     <= '0;
      r_eof           <= 1'b0;
    end else begin
      array_banksel_n <= !(w_next inside {S_ROW_OPEN, S_WR_CMD, S_WR_WAIT, S_WR_RECOVER});
      array_cas_wr    <= (w_next == S_WR_CMD);
      wr_done         <= (w_next == S_DONE);
      // Row is captured only from the opening frame; continuation rows are ignored.
      if ((r_state == S_IDLE) && w_accept && w_sof) begin
        array_raddr <= w_addr[AXI_ADDR_WIDTH-1 -: 14];
      end
      if (w_load_frame) begin
        array_caddr_wr <= w_addr[5:0];
        array_wdata    <= w_data;
        r_eof          <= w_eof;
      end
    end
  end

endmodule

// File: tb/tb_array_wr_ctrl.sv
// tb_array_wr_ctrl: self-checking bench for array_wr_ctrl.
// Directed table of bursts with hand-derived cycle expectations, hand-written
// corner sequences (dropped sof=0 frame, reset during recovery), then random
// bursts checked against a cycle-count model of the burst timeline.
module tb_array_wr_ctrl;
  localparam int AW = 20;
  localparam int DW = 64;
  localparam int FW = AW + DW + 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    trcd, twr, trp;
  logic [FW-1:0] fdata;
  logic          fvalid;
  logic          fready;
  logic          wr_done;
  logic          banksel_n;
  logic [13:0]   raddr;
  logic          cas_wr;
  logic [5:0]    caddr;
  logic [DW-1:0] wdata;

  array_wr_ctrl #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
    .clk               (clk),
    .rst               (rst),
    .mc_trcd_cfg       (trcd),
    .mc_twr_cfg        (twr),
    .mc_trp_cfg        (trp),
    .axi_frame_wr_data (fdata),
    .axi_frame_wr_valid(fvalid),
    .axi_frame_wr_ready(fready),
    .wr_done           (wr_done),
    .array_banksel_n   (banksel_n),
    .array_raddr       (raddr),
    .array_cas_wr      (cas_wr),
    .array_caddr_wr    (caddr),
    .array_wdata       (wdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk_frame(input logic sof, input logic eof,
                                             input logic [AW-1:0] addr, input logic [DW-1:0] d);
    return {sof, eof, 1'b1, addr, d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Burst stimulus and model expectations.
  int            b_n;
  logic [AW-1:0] b_addr [4];
  logic [DW-1:0] b_data [4];
  int            b_gap  [4];
  logic          b_sof  [4];
  int            e_cas  [4];
  int            e_done, e_low_last;
  logic [13:0]   e_row;

  // Observations.
  int          o_cas_cyc [4];
  logic [5:0]  o_caddr   [4];
  logic [DW-1:0] o_wdata [4];
  int          o_ncas, o_done_cyc, o_ndone, o_low_first, o_low_last, o_nlow, o_row_bad;
  logic        o_timeout, o_idle_ready;

  // Drive one burst from IDLE; cycle 1 is the cycle after the sof accept edge.
  task automatic run_burst();
    int beat;
    int waits;
    bit finished;
    o_ncas = 0; o_done_cyc = -1; o_ndone = 0; o_low_first = -1; o_low_last = -1;
    o_nlow = 0; o_row_bad = 0; o_timeout = 1'b0; o_idle_ready = 1'b0;
    check("start_ready", fready, 1'b1);
    fdata  = mk_frame(1'b1, b_n == 1, b_addr[0], b_data[0]);
    fvalid = 1'b1;
    @(posedge clk);
    #1;
    cyc = 1;
    beat = 1; waits = 0; finished = 0;
    while (!finished) begin
      if (cas_wr) begin
        if (o_ncas < 4) begin
          o_cas_cyc[o_ncas] = cyc;
          o_caddr[o_ncas]   = caddr;
          o_wdata[o_ncas]   = wdata;
        end
        o_ncas++;
      end
      if (!banksel_n) begin
        if (o_low_first < 0) o_low_first = cyc;
        o_low_last = cyc;
        o_nlow++;
        if (raddr !== e_row) o_row_bad++;
      end
      if (wr_done) begin
        o_done_cyc = cyc;
        o_ndone++;
      end
      fvalid = 1'b0;
      if (o_ndone > 0 && cyc > o_done_cyc) begin
        o_idle_ready = fready;
        finished = 1;
      end else if (fready && beat < b_n) begin
        if (waits < b_gap[beat]) begin
          waits++;
        end else begin
          fdata  = mk_frame(b_sof[beat], beat == b_n - 1, b_addr[beat], b_data[beat]);
          fvalid = 1'b1;
          beat++;
          waits = 0;
        end
      end
      if (!finished && cyc >= 300) begin
        o_timeout = 1'b1;
        finished = 1;
      end
      if (!finished) step();
    end
    fvalid = 1'b0;
  endtask

  task automatic check_burst(input string tag);
    check({tag, "_timeout"}, o_timeout, 1'b0);
    check({tag, "_ncas"}, o_ncas, b_n);
    for (int k = 0; k < b_n && k < o_ncas && k < 4; k++) begin
      check($sformatf("%s_cas%0d_cyc", tag, k), o_cas_cyc[k], e_cas[k]);
      check($sformatf("%s_cas%0d_caddr", tag, k), o_caddr[k], b_addr[k][5:0]);
      check($sformatf("%s_cas%0d_wdata", tag, k), o_wdata[k], b_data[k]);
    end
    check({tag, "_low_first"}, o_low_first, 1);
    check({tag, "_low_last"}, o_low_last, e_low_last);
    check({tag, "_low_count"}, o_nlow, e_low_last);
    check({tag, "_row_bad"}, o_row_bad, 0);
    check({tag, "_done_cyc"}, o_done_cyc, e_done);
    check({tag, "_done_count"}, o_ndone, 1);
    check({tag, "_idle_ready"}, o_idle_ready, 1'b1);
  endtask

  typedef struct {
    logic [7:0]          trcd, twr, trp;
    int                  n;
    logic [3:0][AW-1:0]  addr;
    logic [3:0][DW-1:0]  data;
    logic [3:0][7:0]     gap;
    logic [3:0][15:0]    e_cas;
    int                  e_done;
    int                  e_low_last;
    logic [13:0]         e_row;
  } vec_t;

  vec_t vecs [4];

  task automatic load_vec(input int i);
    trcd = vecs[i].trcd; twr = vecs[i].twr; trp = vecs[i].trp;
    b_n = vecs[i].n;
    for (int k = 0; k < 4; k++) begin
      b_addr[k] = vecs[i].addr[k];
      b_data[k] = vecs[i].data[k];
      b_gap[k]  = int'(vecs[i].gap[k]);
      b_sof[k]  = 1'b0;
      e_cas[k]  = int'(vecs[i].e_cas[k]);
    end
    e_done = vecs[i].e_done; e_low_last = vecs[i].e_low_last; e_row = vecs[i].e_row;
  endtask

  function automatic int eff(input logic [7:0] c);
    return (c == 8'd0) ? 1 : int'(c);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_low, cnt_cas, cnt_done, cnt_busy;
    // Three-frame burst from the test plan.
    vecs[0] = '{8'd2, 8'd3, 8'd2, 3,
                {20'd0, 20'd102, 20'd101, 20'd100},
                {64'd0, 64'd102, 64'd101, 64'd100},
                {8'd0, 8'd0, 8'd0, 8'd0},
                {16'd0, 16'd7, 16'd5, 16'd3}, 13, 10, 14'd1};
    // Single frame, all cfg 0 treated as 1.
    vecs[1] = '{8'd0, 8'd0, 8'd0, 1,
                {20'd0, 20'd0, 20'd0, 20'h00FC5},
                {64'd0, 64'd0, 64'd0, 64'hDEADBEEF_CAFEF00D},
                {8'd0, 8'd0, 8'd0, 8'd0},
                {16'd0, 16'd0, 16'd0, 16'd2}, 5, 3, 14'd63};
    // Valid low for 4 cycles in WR_WAIT.
    vecs[2] = '{8'd1, 8'd1, 8'd1, 2,
                {20'd0, 20'd0, 20'h00041, 20'h00040},
                {64'd0, 64'd0, 64'h55AA, 64'hAA55},
                {8'd0, 8'd0, 8'd4, 8'd0},
                {16'd0, 16'd0, 16'd8, 16'd2}, 11, 9, 14'd1};
    // Continuation frame on a different row keeps the original row.
    vecs[3] = '{8'd3, 8'd2, 8'd1, 2,
                {20'd0, 20'd0, 20'hABC07, 20'h12345},
                {64'd0, 64'd0, 64'h1111, 64'h2222},
                {8'd0, 8'd0, 8'd0, 8'd0},
                {16'd0, 16'd0, 16'd6, 16'd4}, 10, 8, 14'h48D};

    fvalid = 1'b0; fdata = '0; trcd = 8'd0; twr = 8'd0; trp = 8'd0;
    #1 rst = 1'b1;
    #2;
    check("rst_ready", fready, 1'b0);
    check("rst_banksel_n", banksel_n, 1'b1);
    check("rst_cas_wr", cas_wr, 1'b0);
    check("rst_wr_done", wr_done, 1'b0);
    check("rst_raddr", raddr, 14'd0);
    check("rst_caddr", caddr, 6'd0);
    check("rst_wdata", wdata, 64'd0);
    @(posedge clk); @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1 check("rel_ready", fready, 1'b1);
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      load_vec(i);
      run_burst();
      check_burst($sformatf("vec%0d", i));
    end

    // sof=0 frame in IDLE is accepted and dropped.
    fdata  = mk_frame(1'b0, 1'b1, 20'h00080, 64'h77);
    fvalid = 1'b1;
    check("drop_ready", fready, 1'b1);
    step();
    fvalid = 1'b0;
    cnt_low = 0; cnt_cas = 0; cnt_done = 0; cnt_busy = 0;
    for (int k = 0; k < 10; k++) begin
      if (!banksel_n) cnt_low++;
      if (cas_wr) cnt_cas++;
      if (wr_done) cnt_done++;
      if (!fready) cnt_busy++;
      step();
    end
    check("drop_banksel_low", cnt_low, 0);
    check("drop_cas", cnt_cas, 0);
    check("drop_done", cnt_done, 0);
    check("drop_not_ready", cnt_busy, 0);

    // Reset pulse in WR_RECOVER.
    trcd = 8'd1; twr = 8'd5; trp = 8'd1;
    fdata  = mk_frame(1'b1, 1'b1, 20'hFFFC3, 64'h0123_4567_89AB_CDEF);
    fvalid = 1'b1;
    step();
    fvalid = 1'b0;
    step();
    check("rr_cas", cas_wr, 1'b1);
    step(); step();
    check("rr_recover_banksel", banksel_n, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("rr_banksel_n", banksel_n, 1'b1);
    check("rr_ready", fready, 1'b0);
    check("rr_raddr", raddr, 14'd0);
    check("rr_caddr", caddr, 6'd0);
    check("rr_wdata", wdata, 64'd0);
    check("rr_wr_done", wr_done, 1'b0);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1 check("rr_rel_ready", fready, 1'b1);
    cnt_low = 0; cnt_done = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (!banksel_n) cnt_low++;
      if (wr_done) cnt_done++;
    end
    check("rr_no_done", cnt_done, 0);
    check("rr_no_row", cnt_low, 0);
    load_vec(0);
    run_burst();
    check_burst("after_rst");

    // Random bursts against the timeline model.
    for (int r = 0; r < 25; r++) begin
      trcd = 8'($urandom_range(0, 4));
      twr  = 8'($urandom_range(0, 4));
      trp  = 8'($urandom_range(0, 4));
      b_n  = $urandom_range(1, 4);
      for (int k = 0; k < 4; k++) begin
        b_addr[k] = AW'($urandom);
        b_data[k] = {$urandom, $urandom};
        b_gap[k]  = (k == 0) ? 0 : $urandom_range(0, 3);
        b_sof[k]  = 1'($urandom);
      end
      e_row    = b_addr[0][AW-1 -: 14];
      e_cas[0] = eff(trcd) + 1;
      for (int k = 1; k < 4; k++) e_cas[k] = e_cas[k-1] + 2 + b_gap[k];
      e_low_last = e_cas[b_n-1] + eff(twr);
      e_done     = e_low_last + eff(trp) + 1;
      run_burst();
      check_burst($sformatf("rnd%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
